branch_redirect_ctrl: RTL and testbench

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

---
 rtl/branch_redirect_pkg.sv | 19 +
 rtl/redirect_priority_arbiter.sv | 32 +++
 rtl/branch_redirect_ctrl.sv | 130 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_pkg.sv
// Shared types and constants for the branch redirect controller and its arbiter.
package branch_redirect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } redirect_state_e;

  localparam int GRANT_W    = 3;
  localparam int GRANT_BR   = 0;
  localparam int GRANT_JMP  = 1;
  localparam int GRANT_TRAP = 2;

  // Wide enough for the largest legal flush length (15).
  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/redirect_priority_arbiter.sv
// Fixed-priority (trap > jmp > br) selector returning a one-hot grant and its address.
module redirect_priority_arbiter
  import branch_redirect_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  br_req,
  input  logic [ADDR_WIDTH-1:0] br_addr,
  input  logic                  jmp_req,
  input  logic [ADDR_WIDTH-1:0] jmp_addr,
  input  logic                  trap_req,
  input  logic [ADDR_WIDTH-1:0] trap_addr,
  output logic [GRANT_W-1:0]    grant,
  output logic [ADDR_WIDTH-1:0] addr
);

  always_comb begin
    grant = '0;
    addr  = '0;
    if (trap_req) begin
      grant[GRANT_TRAP] = 1'b1;
      addr              = trap_addr;
    end else if (jmp_req) begin
      grant[GRANT_JMP] = 1'b1;
      addr             = jmp_addr;
    end else if (br_req) begin
      grant[GRANT_BR] = 1'b1;
      addr            = br_addr;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Sequences a taken branch/jump/trap through load, redirect and flush of the
// branch-destination register; only traps may preempt an in-flight redirect.
module branch_redirect_ctrl
  import branch_redirect_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  br_req,
  input  logic [ADDR_WIDTH-1:0] br_addr,
  input  logic                  jmp_req,
  input  logic [ADDR_WIDTH-1:0] jmp_addr,
  input  logic                  trap_req,
  input  logic [ADDR_WIDTH-1:0] trap_addr,
  input  logic                  pc_ready,
  output logic [GRANT_W-1:0]    grant,
  output logic                  bda_load,
  output logic [ADDR_WIDTH-1:0] bda_d,
  output logic                  bda_cs,
  output logic                  redirect_valid,
  output logic                  flush,
  output logic                  busy
);

  redirect_state_e         state_q, state_nx;
  logic [FLUSH_CNT_W-1:0]  cnt_q, cnt_nx;
  logic                    trap_q, trap_nx;
  logic                    idle;
  logic [GRANT_W-1:0]      arb_grant;
  logic [ADDR_WIDTH-1:0]   arb_addr;
  logic [GRANT_W-1:0]      grant_nx;
  logic                    load_nx, cs_nx, valid_nx, flush_nx, busy_nx;

  assign idle = (state_q == ST_IDLE);

  // br/jmp only compete from IDLE; a trap competes unless a trap is already being served.
  redirect_priority_arbiter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_arbiter (
    .br_req    (br_req & idle),
    .br_addr   (br_addr),
    .jmp_req   (jmp_req & idle),
    .jmp_addr  (jmp_addr),
    .trap_req  (trap_req & ~trap_q),
    .trap_addr (trap_addr),
    .grant     (arb_grant),
    .addr      (arb_addr)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      trap_q         <= 1'b0;
      grant          <= '0;
      bda_load       <= 1'b0;
      bda_d          <= '0;
      bda_cs         <= 1'b1;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      busy           <= 1'b0;
    end else if (Tick) begin
      state_q        <= state_nx;
      cnt_q          <= cnt_nx;
      trap_q         <= trap_nx;
      grant          <= grant_nx;
      bda_load       <= load_nx;
      bda_cs         <= cs_nx;
      redirect_valid <= valid_nx;
      flush          <= flush_nx;
      busy           <= busy_nx;
      if (|arb_grant) begin
        bda_d <= arb_addr;
      end
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    trap_nx  = trap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          state_nx = ST_LOAD;
          trap_nx  = arb_grant[GRANT_TRAP];
        end
      end
      ST_LOAD: begin
        state_nx = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (pc_ready) begin
          state_nx = ST_FLUSH;
          cnt_nx   = FLUSH_CNT_W'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (cnt_q <= FLUSH_CNT_W'(1)) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          trap_nx  = 1'b0;
        end else begin
          cnt_nx = cnt_q - FLUSH_CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Trap preemption restarts the sequence from LOAD with a cleared flush count.
    if (!idle && arb_grant[GRANT_TRAP]) begin
      state_nx = ST_LOAD;
      cnt_nx   = '0;
      trap_nx  = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they can be registered alongside it.
  always_comb begin
    grant_nx = arb_grant;
    load_nx  = (state_nx == ST_LOAD);
    cs_nx    = !((state_nx == ST_REDIRECT) || (state_nx == ST_FLUSH));
    valid_nx = (state_nx == ST_REDIRECT);
    flush_nx = (state_nx == ST_FLUSH);
    busy_nx  = (state_nx != ST_IDLE);
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Vector-table and scoreboard bench for branch_redirect_ctrl (default and single-cycle flush).
module tb_branch_redirect_ctrl;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_RED  = 2;
  localparam int S_FL   = 3;

  typedef struct packed {
    logic        tick;
    logic        br;
    logic        jmp;
    logic        trap;
    logic        pcr;
    logic [31:0] ba;
    logic [31:0] ja;
    logic [31:0] ta;
  } stim_t;

  typedef struct packed {
    logic [2:0]  grant;
    logic        load;
    logic [31:0] d;
    logic        cs;
    logic        rv;
    logic        fl;
    logic        busy;
  } exp_t;

  typedef struct {
    string name;
    stim_t s;
    exp_t  e;
  } vec_t;

  typedef struct {
    string name;
    exp_t  e;
    int    which;
  } sb_t;

  logic        Clock, Reset, Tick;
  logic        br_req, jmp_req, trap_req, pc_ready;
  logic [31:0] br_addr, jmp_addr, trap_addr;
  logic [2:0]  grant, grant_f1;
  logic        bda_load, bda_cs, redirect_valid, flush, busy;
  logic        bda_load_f1, bda_cs_f1, redirect_valid_f1, flush_f1, busy_f1;
  logic [31:0] bda_d, bda_d_f1;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  sb_t  sb[$];
  int   gcyc[$];

  branch_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(2)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .br_req(br_req), .br_addr(br_addr), .jmp_req(jmp_req), .jmp_addr(jmp_addr),
    .trap_req(trap_req), .trap_addr(trap_addr), .pc_ready(pc_ready),
    .grant(grant), .bda_load(bda_load), .bda_d(bda_d), .bda_cs(bda_cs),
    .redirect_valid(redirect_valid), .flush(flush), .busy(busy)
  );

  branch_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(1)) dut_f1 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .br_req(br_req), .br_addr(br_addr), .jmp_req(jmp_req), .jmp_addr(jmp_addr),
    .trap_req(trap_req), .trap_addr(trap_addr), .pc_ready(pc_ready),
    .grant(grant_f1), .bda_load(bda_load_f1), .bda_d(bda_d_f1), .bda_cs(bda_cs_f1),
    .redirect_valid(redirect_valid_f1), .flush(flush_f1), .busy(busy_f1)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t exp_of(logic [2:0] g, int st, logic [31:0] d);
    exp_t e;
    e.grant = g;
    e.load  = (st == S_LOAD);
    e.d     = d;
    e.cs    = !((st == S_RED) || (st == S_FL));
    e.rv    = (st == S_RED);
    e.fl    = (st == S_FL);
    e.busy  = (st != S_IDLE);
    return e;
  endfunction

  function automatic vec_t mk(string name, logic t, logic b, logic j, logic tr, logic p,
                              logic [31:0] ba, logic [31:0] ja, logic [31:0] ta,
                              logic [2:0] g, int st, logic [31:0] d);
    vec_t v;
    v.name = name;
    v.s = '{tick: t, br: b, jmp: j, trap: tr, pcr: p, ba: ba, ja: ja, ta: ta};
    v.e = exp_of(g, st, d);
    return v;
  endfunction

  function automatic exp_t obs(int which);
    exp_t o;
    if (which == 1)
      o = '{grant: grant_f1, load: bda_load_f1, d: bda_d_f1, cs: bda_cs_f1,
            rv: redirect_valid_f1, fl: flush_f1, busy: busy_f1};
    else
      o = '{grant: grant, load: bda_load, d: bda_d, cs: bda_cs,
            rv: redirect_valid, fl: flush, busy: busy};
    return o;
  endfunction

  task automatic check(string name, exp_t got, exp_t req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got grant=%b load=%b d=%h cs=%b rv=%b flush=%b busy=%b, required grant=%b load=%b d=%h cs=%b rv=%b flush=%b busy=%b",
               name, got.grant, got.load, got.d, got.cs, got.rv, got.fl, got.busy,
               req.grant, req.load, req.d, req.cs, req.rv, req.fl, req.busy);
    end
  endtask

  task automatic check_int(string name, int got, int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic drive(stim_t s);
    Tick = s.tick; br_req = s.br; jmp_req = s.jmp; trap_req = s.trap; pc_ready = s.pcr;
    br_addr = s.ba; jmp_addr = s.ja; trap_addr = s.ta;
  endtask

  task automatic run_vec(vec_t v, int which);
    sb_t x;
    drive(v.s);
    sb.push_back('{name: v.name, e: v.e, which: which});
    @(posedge Clock);
    #1;
    x = sb.pop_front();
    check(x.name, obs(x.which), x.e);
  endtask

  initial begin
    drive('0);
    Tick = 1'b1;
    Reset = 1'b1;
    #2;
    check("reset_state", obs(0), exp_of(3'b000, S_IDLE, 32'h0));
    check("reset_state_f1", obs(1), exp_of(3'b000, S_IDLE, 32'h0));
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    // Basic branch redirect; br/jmp held during busy get no grant.
    vecs.push_back(mk("br_grant",         1,1,0,0,0, 32'h40,0,0, 3'b001, S_LOAD, 32'h40));
    vecs.push_back(mk("busy_ignores_req", 1,1,1,0,0, 32'h40,0,0, 3'b000, S_RED,  32'h40));
    vecs.push_back(mk("redirect_wait",    1,1,1,0,0, 32'h40,0,0, 3'b000, S_RED,  32'h40));
    vecs.push_back(mk("redirect_accept",  1,0,0,0,1, 32'h40,0,0, 3'b000, S_FL,   32'h40));
    vecs.push_back(mk("flush_2nd",        1,0,0,0,0, 32'h40,0,0, 3'b000, S_FL,   32'h40));
    vecs.push_back(mk("flush_done",       1,0,0,0,0, 32'h40,0,0, 3'b000, S_IDLE, 32'h40));
    vecs.push_back(mk("idle_hold_d",      1,0,0,0,0, 32'h40,0,0, 3'b000, S_IDLE, 32'h40));
    // Priority: trap, then held jmp, then held br.
    vecs.push_back(mk("all3_trap_wins",   1,1,1,1,1, 32'h10,32'h20,32'h80, 3'b100, S_LOAD, 32'h80));
    vecs.push_back(mk("trap_seq_red",     1,1,1,0,1, 32'h10,32'h20,32'h80, 3'b000, S_RED,  32'h80));
    vecs.push_back(mk("trap_seq_fl1",     1,1,1,0,1, 32'h10,32'h20,32'h80, 3'b000, S_FL,   32'h80));
    vecs.push_back(mk("trap_seq_fl2",     1,1,1,0,1, 32'h10,32'h20,32'h80, 3'b000, S_FL,   32'h80));
    vecs.push_back(mk("no_grant_on_ret",  1,1,1,0,1, 32'h10,32'h20,32'h80, 3'b000, S_IDLE, 32'h80));
    vecs.push_back(mk("jmp_second",       1,1,1,0,1, 32'h10,32'h20,32'h80, 3'b010, S_LOAD, 32'h20));
    vecs.push_back(mk("jmp_seq_red",      1,1,0,0,1, 32'h10,32'h20,32'h80, 3'b000, S_RED,  32'h20));
    vecs.push_back(mk("jmp_seq_fl1",      1,1,0,0,1, 32'h10,32'h20,32'h80, 3'b000, S_FL,   32'h20));
    vecs.push_back(mk("jmp_seq_fl2",      1,1,0,0,1, 32'h10,32'h20,32'h80, 3'b000, S_FL,   32'h20));
    vecs.push_back(mk("jmp_seq_idle",     1,1,0,0,1, 32'h10,32'h20,32'h80, 3'b000, S_IDLE, 32'h20));
    vecs.push_back(mk("br_third",         1,1,0,0,1, 32'h10,32'h20,32'h80, 3'b001, S_LOAD, 32'h10));
    vecs.push_back(mk("br_seq_red",       1,0,0,0,1, 32'h10,32'h20,32'h80, 3'b000, S_RED,  32'h10));
    vecs.push_back(mk("br_seq_fl1",       1,0,0,0,1, 32'h10,32'h20,32'h80, 3'b000, S_FL,   32'h10));
    vecs.push_back(mk("br_seq_fl2",       1,0,0,0,1, 32'h10,32'h20,32'h80, 3'b000, S_FL,   32'h10));
    vecs.push_back(mk("br_seq_idle",      1,0,0,0,1, 32'h10,32'h20,32'h80, 3'b000, S_IDLE, 32'h10));
    // Tick gating: pc_ready only on untick cycles must not advance REDIRECT.
    vecs.push_back(mk("tick_br_grant",    1,1,0,0,0, 32'h40,0,0, 3'b001, S_LOAD, 32'h40));
    vecs.push_back(mk("tick0_grant_hold", 0,0,0,0,0, 32'h40,0,0, 3'b001, S_LOAD, 32'h40));
    vecs.push_back(mk("tick_to_red",      1,0,0,0,0, 32'h40,0,0, 3'b000, S_RED,  32'h40));
    vecs.push_back(mk("tick0_pcr_a",      0,0,0,0,1, 32'h40,0,0, 3'b000, S_RED,  32'h40));
    vecs.push_back(mk("tick0_pcr_b",      0,0,0,0,1, 32'h40,0,0, 3'b000, S_RED,  32'h40));
    vecs.push_back(mk("tick1_no_pcr",     1,0,0,0,0, 32'h40,0,0, 3'b000, S_RED,  32'h40));
    vecs.push_back(mk("tick1_pcr",        1,0,0,0,1, 32'h40,0,0, 3'b000, S_FL,   32'h40));
    vecs.push_back(mk("tick0_flush_hold", 0,0,0,0,0, 32'h40,0,0, 3'b000, S_FL,   32'h40));
    vecs.push_back(mk("tick_flush_2nd",   1,0,0,0,0, 32'h40,0,0, 3'b000, S_FL,   32'h40));
    vecs.push_back(mk("tick_flush_done",  1,0,0,0,0, 32'h40,0,0, 3'b000, S_IDLE, 32'h40));
    // Trap preempts in the second flush cycle; a second trap while serving one does not.
    vecs.push_back(mk("pre_br_grant",     1,1,0,0,0, 32'h40,0,0, 3'b001, S_LOAD, 32'h40));
    vecs.push_back(mk("pre_red",          1,0,0,0,1, 32'h40,0,0, 3'b000, S_RED,  32'h40));
    vecs.push_back(mk("pre_fl1",          1,0,0,0,1, 32'h40,0,0, 3'b000, S_FL,   32'h40));
    vecs.push_back(mk("pre_fl2",          1,0,0,0,1, 32'h40,0,0, 3'b000, S_FL,   32'h40));
    vecs.push_back(mk("trap_preempt",     1,0,0,1,1, 32'h40,0,32'h100, 3'b100, S_LOAD, 32'h100));
    vecs.push_back(mk("trap_no_repreempt",1,0,0,1,1, 32'h40,0,32'h200, 3'b000, S_RED,  32'h100));
    vecs.push_back(mk("trap_held_fl1",    1,0,0,1,1, 32'h40,0,32'h200, 3'b000, S_FL,   32'h100));
    vecs.push_back(mk("trap_fl2",         1,0,0,0,1, 32'h40,0,32'h200, 3'b000, S_FL,   32'h100));
    vecs.push_back(mk("trap_done",        1,0,0,0,1, 32'h40,0,32'h200, 3'b000, S_IDLE, 32'h100));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], 0);

    // Asynchronous reset in the middle of LOAD.
    run_vec(mk("rst_seq_grant", 1,1,0,0,0, 32'h40,0,0, 3'b001, S_LOAD, 32'h40), 0);
    #3;
    Reset = 1'b1;
    #1;
    check("async_reset_mid_load", obs(0), exp_of(3'b000, S_IDLE, 32'h0));
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++)
      run_vec(mk("post_reset_quiet", 1,0,0,0,1, 32'h40,0,0, 3'b000, S_IDLE, 32'h0), 0);
    run_vec(mk("first_tick_after_reset", 1,1,0,0,0, 32'h44,0,0, 3'b001, S_LOAD, 32'h44), 0);

    // Single-cycle flush variant with a continuously asserted jump.
    Reset = 1'b1;
    #1;
    check("f1_reset", obs(1), exp_of(3'b000, S_IDLE, 32'h0));
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      int ph;
      ph = k % 4;
      run_vec(mk("f1_b2b_jmp", 1,0,1,0,1, 32'h0,32'h20,32'h0,
                 (ph == 0) ? 3'b010 : 3'b000,
                 (ph == 0) ? S_LOAD : (ph == 1) ? S_RED : (ph == 2) ? S_FL : S_IDLE,
                 32'h20), 1);
      if (grant_f1[1]) gcyc.push_back(k);
    end
    check_int("f1_grant_count", gcyc.size(), 3);
    for (int i = 1; i < gcyc.size(); i++)
      check_int("f1_grant_spacing", gcyc[i] - gcyc[i-1], 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
